// File: rtl/cycle_seq_pkg.sv
// rtl/cycle_seq_pkg.sv - state encodings, instruction classes and I/O timeout default
package cycle_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM      = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WAIT_OUT = 3'd5,
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU        = 3'd0,
        CL_LOAD       = 3'd1,
        CL_STORE      = 3'd2,
        CL_BRANCH     = 3'd3,
        CL_INPUT      = 3'd4,
        CL_OUTPUT     = 3'd5,
        CL_INST_STORE = 3'd6,
        CL_HALT       = 3'd7
    } inst_class_t;

    localparam logic [15:0] IO_TIMEOUT_DEFAULT = 16'd50000;

endpackage

// File: rtl/io_wait_timer.sv
// rtl/io_wait_timer.sv - wait-state cycle counter with timeout compare
module io_wait_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    // Expires on the cycle the count reaches limit-1; a zero limit expires at once.
    assign expired = enable && (({1'b0, count} + 17'd1) >= {1'b0, limit});

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - multi-cycle instruction sequencer with I/O wait timeout
module cycle_sequencer
    import cycle_seq_pkg::*;
#(
    parameter logic [15:0] IO_TIMEOUT = IO_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  inst_class,
    input  logic        wr_en_dec,
    input  logic        in_ready,
    input  logic        out_done,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        inst_write,
    output logic        in_req,
    output logic        new_out,
    output logic [2:0]  state,
    output logic        halted,
    output logic        io_error,
    output logic [31:0] retired
);

    state_t      state_q;
    state_t      state_d;
    inst_class_t cls_q;
    logic        wr_q;
    logic        first_wait_q;
    logic        in_timeout_q;
    logic        waiting;
    logic        expired;
    logic        handshake;

    assign waiting   = (state_q == ST_WAIT_IN) || (state_q == ST_WAIT_OUT);
    assign handshake = ((state_q == ST_WAIT_IN) && in_ready) ||
                       ((state_q == ST_WAIT_OUT) && out_done);

    io_wait_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .limit   (IO_TIMEOUT),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CL_ALU, CL_BRANCH:                 state_d = ST_WB;
                    CL_LOAD, CL_STORE, CL_INST_STORE:  state_d = ST_MEM;
                    CL_INPUT:                          state_d = ST_WAIT_IN;
                    CL_OUTPUT:                         state_d = ST_WAIT_OUT;
                    CL_HALT:                           state_d = ST_HALT;
                    default:                           state_d = ST_WB;
                endcase
            end
            ST_MEM:      state_d = ST_WB;
            ST_WAIT_IN:  if (in_ready || expired) state_d = ST_WB;
            ST_WAIT_OUT: if (out_done || expired) state_d = ST_WB;
            ST_WB:       state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cls_q        <= CL_ALU;
            wr_q         <= 1'b0;
            first_wait_q <= 1'b0;
            in_timeout_q <= 1'b0;
            io_error     <= 1'b0;
            retired      <= '0;
        end else begin
            state_q      <= state_d;
            first_wait_q <= (state_q == ST_EXEC);
            if (state_q == ST_FETCH) begin
                cls_q        <= inst_class_t'(inst_class);
                wr_q         <= wr_en_dec;
                in_timeout_q <= 1'b0;
            end
            // A handshake on the expiry cycle wins over the timeout.
            if (waiting && expired && !handshake) begin
                io_error <= 1'b1;
                if (state_q == ST_WAIT_IN) in_timeout_q <= 1'b1;
            end
            if (state_q == ST_WB) retired <= retired + 32'd1;
        end
    end

    assign state      = state_q;
    assign pc_write   = (state_q == ST_WB);
    assign reg_write  = (state_q == ST_WB) && wr_q && !in_timeout_q;
    assign mem_write  = (state_q == ST_MEM) && (cls_q == CL_STORE);
    assign inst_write = (state_q == ST_MEM) && (cls_q == CL_INST_STORE);
    assign in_req     = (state_q == ST_WAIT_IN);
    assign new_out    = (state_q == ST_WAIT_OUT) && first_wait_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - scoreboard bench for cycle_sequencer
module tb_cycle_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WIN = 3'd4, S_WOUT = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;
    // Strobe vector order: pc_write, reg_write, mem_write, inst_write, in_req, new_out
    localparam logic [5:0] Z = 6'b000000, PC = 6'b100000, PCRW = 6'b110000,
                           MW = 6'b001000, IW = 6'b000100, IR = 6'b000010, NO = 6'b000001;

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  str;
        logic        h;
        logic        err;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, run, wr_en_dec, in_ready, out_done;
    logic [2:0]  inst_class;
    logic        pc_write, reg_write, mem_write, inst_write, in_req, new_out;
    logic [2:0]  state;
    logic        halted, io_error;
    logic [31:0] retired;

    exp_t        exp_q[$];
    logic        exp_err;
    logic [31:0] exp_ret;
    int          errors = 0;
    int          checks = 0;

    cycle_sequencer #(.IO_TIMEOUT(16'd8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .inst_class (inst_class),
        .wr_en_dec  (wr_en_dec),
        .in_ready   (in_ready),
        .out_done   (out_done),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .inst_write (inst_write),
        .in_req     (in_req),
        .new_out    (new_out),
        .state      (state),
        .halted     (halted),
        .io_error   (io_error),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", {29'd0, state}, {29'd0, e.st});
            chk("strobes", {26'd0, pc_write, reg_write, mem_write, inst_write, in_req, new_out},
                {26'd0, e.str});
            chk("halted_io_error", {30'd0, halted, io_error}, {30'd0, e.h, e.err});
            chk("retired", retired, e.ret);
            chk("write_exclusive", {30'd0, 2'(32'(pc_write) + 32'(mem_write) + 32'(inst_write))} <= 32'd1,
                32'd1);
        end
    end

    // Pushes the expected outputs of the current cycle, then advances one clock.
    task automatic cyc(input int n, input logic [2:0] st, input logic [5:0] str, input logic h);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{st: st, str: str, h: h, err: exp_err, ret: exp_ret});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; inst_class = 3'd0; wr_en_dec = 1'b0;
        in_ready = 1'b0; out_done = 1'b0;
        exp_err = 1'b0; exp_ret = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, S_IDLE, Z, 0);

        // INPUT interrupted by reset in its third wait cycle
        reset = 1'b0; run = 1'b1; inst_class = 3'd4; wr_en_dec = 1'b1;
        cyc(1, S_IDLE, Z, 0);
        cyc(1, S_FETCH, Z, 0);
        cyc(1, S_EXEC, Z, 0);
        cyc(2, S_WIN, IR, 0);
        reset = 1'b1;
        cyc(1, S_WIN, IR, 0);
        reset = 1'b0; inst_class = 3'd0; wr_en_dec = 1'b1;
        cyc(1, S_IDLE, Z, 0);

        // two back-to-back ALU instructions
        for (int k = 0; k < 2; k++) begin
            cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(1, S_WB, PCRW, 0);
            exp_ret++;
        end

        inst_class = 3'd2; wr_en_dec = 1'b0;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(1, S_MEM, MW, 0); cyc(1, S_WB, PC, 0);
        exp_ret++;

        inst_class = 3'd6; wr_en_dec = 1'b0;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(1, S_MEM, IW, 0); cyc(1, S_WB, PC, 0);
        exp_ret++;

        inst_class = 3'd1; wr_en_dec = 1'b1;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(1, S_MEM, Z, 0); cyc(1, S_WB, PCRW, 0);
        exp_ret++;

        // INPUT with in_ready in the sixth wait cycle
        inst_class = 3'd4; wr_en_dec = 1'b1;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(5, S_WIN, IR, 0);
        in_ready = 1'b1; cyc(1, S_WIN, IR, 0); in_ready = 1'b0;
        cyc(1, S_WB, PCRW, 0);
        exp_ret++;

        // INPUT handshake on the same cycle as the timeout
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0); cyc(7, S_WIN, IR, 0);
        in_ready = 1'b1; cyc(1, S_WIN, IR, 0); in_ready = 1'b0;
        cyc(1, S_WB, PCRW, 0);
        exp_ret++;

        // OUTPUT timeout
        inst_class = 3'd5; wr_en_dec = 1'b0;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0);
        cyc(1, S_WOUT, NO, 0); cyc(7, S_WOUT, Z, 0);
        exp_err = 1'b1;
        cyc(1, S_WB, PC, 0);
        exp_ret++;

        // INPUT timeout suppresses reg_write; run drops mid-instruction
        inst_class = 3'd4; wr_en_dec = 1'b1;
        cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0);
        run = 1'b0;
        cyc(8, S_WIN, IR, 0);
        cyc(1, S_WB, PC, 0);
        exp_ret++;
        cyc(2, S_IDLE, Z, 0);

        // BRANCH with sticky io_error, returning to IDLE
        run = 1'b1; inst_class = 3'd3; wr_en_dec = 1'b0;
        cyc(1, S_IDLE, Z, 0); cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0);
        run = 1'b0;
        cyc(1, S_WB, PC, 0);
        exp_ret++;
        cyc(1, S_IDLE, Z, 0);

        // HALT holds until reset
        run = 1'b1; inst_class = 3'd7; wr_en_dec = 1'b1;
        cyc(1, S_IDLE, Z, 0); cyc(1, S_FETCH, Z, 0); cyc(1, S_EXEC, Z, 0);
        cyc(100, S_HALT, Z, 1);
        reset = 1'b1;
        cyc(1, S_HALT, Z, 1);
        reset = 1'b0; run = 1'b0; exp_err = 1'b0; exp_ret = 32'd0;
        cyc(2, S_IDLE, Z, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter IO_TIMEOUT, default 16'd50000, the maximum number of cycles spent in an I/O wait state.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port run  in  1  permits starting a new instruction.
REQ-005 SHALL have port inst_class  in  3  class code from the control decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 INPUT, 5 OUTPUT, 6 INST_STORE, 7 HALT.
REQ-006 SHALL have port wr_en_dec  in  1  decoder flag: the instruction writes the register file.
REQ-007 SHALL have ports in_ready and out_done  in  1 each  I/O module handshake returns.
REQ-008 SHALL have outputs pc_write, reg_write, mem_write, inst_write, in_req and new_out, each 1 bit, driving the datapath strobes of the same names.
REQ-009 SHALL have outputs state (3), halted (1), io_error (1) and retired (32).

Function
REQ-010 SHALL use the states IDLE=0, FETCH=1, EXEC=2, MEM=3, WAIT_IN=4, WAIT_OUT=5, WB=6 and HALT=7, with state output equal to the current encoding.
REQ-011 IDLE: all strobes 0; go to FETCH when run=1, else stay in IDLE.
REQ-012 FETCH: one cycle; latch inst_class and wr_en_dec at the end of the cycle; go to EXEC.
REQ-013 EXEC transitions by the latched class:
- ALU/BRANCH -> WB
- LOAD/STORE/INST_STORE -> MEM
- INPUT -> WAIT_IN
- OUTPUT -> WAIT_OUT
- HALT -> HALT
REQ-014 MEM: one cycle; mem_write=1 only for STORE and inst_write=1 only for INST_STORE; then go to WB.
REQ-015 WAIT_IN: in_req held 1; leave for WB on the first cycle in_ready=1.
REQ-016 WAIT_OUT: new_out=1 only on the first cycle of the state; leave for WB on the first cycle out_done=1.
REQ-017 Wait timeout:
- A 16-bit wait counter clears on entry to WAIT_IN or WAIT_OUT and increments each cycle in the state.
- When the counter reaches IO_TIMEOUT-1 without a handshake, set io_error (sticky) and go to WB.
- If the handshake and the timeout occur in the same cycle, the handshake wins and io_error is not set.
REQ-018 WB: exactly one cycle.
- pc_write=1.
- reg_write = latched wr_en_dec, except forced 0 after an INPUT timeout.
- retired increments by 1, wrapping from 32'hFFFFFFFF to 0.
- Next state is FETCH if run=1, else IDLE.
REQ-019 Deasserting run mid-instruction SHALL NOT abort the instruction: it completes through WB, then the block goes to IDLE.
REQ-020 HALT: all strobes 0 and halted=1; leaves only on reset.
REQ-021 Latency: ALU/BRANCH 3 cycles, LOAD/STORE/INST_STORE 4 cycles, I/O 3+N cycles (N = cycles in the wait state), counted FETCH to WB inclusive.
REQ-022 All outputs SHALL be registered or decoded from state and latched values only; no combinational path from in_ready or out_done to any strobe.
REQ-023 At most one of mem_write, inst_write or pc_write SHALL be 1 in any cycle.

Reset
REQ-024 reset=1 at a rising edge SHALL, regardless of state (including mid-wait or HALT):
- force state to IDLE
- set all strobes to 0
- clear halted, io_error, retired, the wait counter and the latched class.
REQ-025 A pending I/O handshake at reset SHALL be dropped; in_req is 0 from the next cycle.

Structure
REQ-026 Package cycle_seq_pkg SHALL hold the state encodings, the class codes and the default IO_TIMEOUT.
REQ-027 The wait counter and timeout compare SHALL be one sub-module, io_wait_timer (ports: clk, reset, clear, enable, limit, expired).

Verification
REQ-028 reset, run=1, class=0 with wr_en_dec=1 -> states 1,2,6 then repeat; pc_write and reg_write are 1 in cycle 3; retired=1 after the first WB.
REQ-029 class=2 -> mem_write=1 for exactly one cycle in MEM, reg_write=0 in WB, 4-cycle latency.
REQ-030 class=4, in_ready raised 5 cycles after WAIT_IN entry -> in_req high for 6 cycles, then WB with reg_write=1, io_error=0.
REQ-031 IO_TIMEOUT=8, class=5, out_done held 0 -> new_out pulses once, WB after 8 wait cycles, io_error=1 stays set across later instructions.
REQ-032 class=7 -> halted=1 and state=7 held for 100 cycles; reset -> state=0, retired=0, halted=0.
REQ-033 Reset asserted in the 3rd cycle of WAIT_IN -> in_req=0 and state=0 on the next cycle; retired unchanged from 0.
